sensor_read_sched: RTL and testbench

SENSOR_READ_SCHED -- requirements
Module: sensor_read_sched

---
 rtl/sensor_read_sched.sv | 219 +++++++++++++++++++++
 tb/tb_sensor_read_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_read_sched.sv
// sensor_read_sched
//
// Round-robin read scheduler for three motion sensors (accelerometer,
// gyroscope, magnetometer). When idle it picks one requesting source, issues a
// one-cycle read pulse that clears the source's sticky ready flag, and
// presents the captured 48-bit sample to the filter until the filter
// acknowledges it. If the filter does not acknowledge within TIMEOUT_CYCLES
// cycles, the sample is dropped. A drop pulses timeout_err and increments a
// saturating drop counter.
//
// Parameters
//   TIMEOUT_CYCLES  1..255  PRESENT cycles allowed before the sample is dropped
//
// Ports
//   clk            in   system clock, rising edge
//   n_rst          in   asynchronous active-low reset
//   acc_ready      in   sticky ready flag, accelerometer
//   gyro_ready     in   sticky ready flag, gyroscope
//   mag_ready      in   sticky ready flag, magnetometer
//   acc_data       in   [47:0] accelerometer sample (3 x 16 bit)
//   gyro_data      in   [47:0] gyroscope sample
//   mag_data       in   [47:0] magnetometer sample
//   src_en         in   [2:0] per-source enable {mag, gyro, acc}
//   sample_ack     in   filter accepts the presented sample
//   acc_read       out  one-cycle pulse, clears acc_ready
//   gyro_read      out  one-cycle pulse, clears gyro_ready
//   mag_read       out  one-cycle pulse, clears mag_ready
//   sample_data    out  [47:0] captured sample
//   sample_src     out  [1:0] 0 acc, 1 gyro, 2 mag
//   sample_valid   out  sample_data / sample_src are valid
//   timeout_err    out  one-cycle pulse after a sample was dropped
//   drop_count     out  [7:0] saturating count of dropped samples
//   busy           out  scheduler is presenting a sample
//
// States
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for an enabled ready flag; arbitration happens here
//   PRESENT  | sample held on sample_data, waiting for ack or timeout

module sensor_read_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        acc_ready,
  input  logic        gyro_ready,
  input  logic        mag_ready,
  input  logic [47:0] acc_data,
  input  logic [47:0] gyro_data,
  input  logic [47:0] mag_data,
  input  logic [2:0]  src_en,
  input  logic        sample_ack,
  output logic        acc_read,
  output logic        gyro_read,
  output logic        mag_read,
  output logic [47:0] sample_data,
  output logic [1:0]  sample_src,
  output logic        sample_valid,
  output logic        timeout_err,
  output logic [7:0]  drop_count,
  output logic        busy
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  localparam logic [1:0] SRC_ACC  = 2'd0;
  localparam logic [1:0] SRC_GYRO = 2'd1;
  localparam logic [1:0] SRC_MAG  = 2'd2;

  // Terminal count: the counter starts at 0 in the first PRESENT cycle, so
  // reaching TIMEOUT_CYCLES-1 without ack means TIMEOUT_CYCLES cycles have
  // elapsed.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      next_state;

  logic [1:0]  last_src;
  logic [7:0]  tmo_cnt;
  logic [2:0]  read_vec;

  logic [2:0]  req;
  logic        win_found;
  logic [1:0]  win_src;
  logic [47:0] win_data;
  logic [2:0]  win_onehot;

  logic        do_grant;
  logic        do_drop;

  // --------------------------------------------------------------------------
  // Round-robin arbitration. The search starts at the source after last_src
  // and wraps mag -> acc. last_src never holds 3; if it ever did, it is
  // treated like mag so that acc is searched first.
  // --------------------------------------------------------------------------
  assign req       = {mag_ready, gyro_ready, acc_ready} & src_en;
  assign win_found = |req;

  always_comb begin
    win_src = SRC_ACC;
    case (last_src)
      SRC_ACC: begin
        if (req[1])      win_src = SRC_GYRO;
        else if (req[2]) win_src = SRC_MAG;
        else             win_src = SRC_ACC;
      end
      SRC_GYRO: begin
        if (req[2])      win_src = SRC_MAG;
        else if (req[0]) win_src = SRC_ACC;
        else             win_src = SRC_GYRO;
      end
      default: begin
        if (req[0])      win_src = SRC_ACC;
        else if (req[1]) win_src = SRC_GYRO;
        else             win_src = SRC_MAG;
      end
    endcase
  end

  always_comb begin
    win_data   = mag_data;
    win_onehot = 3'b100;
    case (win_src)
      SRC_ACC: begin
        win_data   = acc_data;
        win_onehot = 3'b001;
      end
      SRC_GYRO: begin
        win_data   = gyro_data;
        win_onehot = 3'b010;
      end
      default: begin
        win_data   = mag_data;
        win_onehot = 3'b100;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    do_grant   = 1'b0;
    do_drop    = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          do_grant   = 1'b1;
          next_state = S_PRESENT;
        end
      end
      S_PRESENT: begin
        // Ack takes priority over a simultaneous timeout.
        if (sample_ack) begin
          next_state = S_IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          do_drop    = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: capture, read pulse, timeout counter, drop accounting.
  // The read pulse is registered off the grant so it lands in the first
  // PRESENT cycle, while sample_valid is already high.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sample_data <= '0;
      sample_src  <= SRC_ACC;
      last_src    <= SRC_MAG;
      tmo_cnt     <= '0;
      read_vec    <= '0;
      timeout_err <= 1'b0;
      drop_count  <= '0;
    end else begin
      read_vec    <= do_grant ? win_onehot : 3'b000;
      timeout_err <= do_drop;

      if (do_grant) begin
        sample_data <= win_data;
        sample_src  <= win_src;
        last_src    <= win_src;
        tmo_cnt     <= '0;
      end else if (state == S_PRESENT && !sample_ack && !do_drop) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end

      if (do_drop && drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  assign acc_read     = read_vec[0];
  assign gyro_read    = read_vec[1];
  assign mag_read     = read_vec[2];
  assign sample_valid = (state == S_PRESENT);
  assign busy         = (state == S_PRESENT);

endmodule

// File: tb/tb_sensor_read_sched.sv
module tb_sensor_read_sched;

  logic        clk;
  logic        n_rst;
  logic        acc_ready, gyro_ready, mag_ready;
  logic [47:0] acc_data, gyro_data, mag_data;
  logic [2:0]  src_en;
  logic        sample_ack;
  logic        acc_read, gyro_read, mag_read;
  logic [47:0] sample_data;
  logic [1:0]  sample_src;
  logic        sample_valid;
  logic        timeout_err;
  logic [7:0]  drop_count;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  localparam logic [47:0] ACC_D  = 48'hA0A0_1111_2222;
  localparam logic [47:0] GYRO_D = 48'hB0B0_3333_4444;
  localparam logic [47:0] MAG_D  = 48'hC0C0_5555_6666;

  sensor_read_sched #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .acc_ready    (acc_ready),
    .gyro_ready   (gyro_ready),
    .mag_ready    (mag_ready),
    .acc_data     (acc_data),
    .gyro_data    (gyro_data),
    .mag_data     (mag_data),
    .src_en       (src_en),
    .sample_ack   (sample_ack),
    .acc_read     (acc_read),
    .gyro_read    (gyro_read),
    .mag_read     (mag_read),
    .sample_data  (sample_data),
    .sample_src   (sample_src),
    .sample_valid (sample_valid),
    .timeout_err  (timeout_err),
    .drop_count   (drop_count),
    .busy         (busy)
  );

  wire [2:0] rd = {mag_read, gyro_read, acc_read};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    acc_ready  = 1'b0;
    gyro_ready = 1'b0;
    mag_ready  = 1'b0;
    acc_data   = ACC_D;
    gyro_data  = GYRO_D;
    mag_data   = MAG_D;
    src_en     = 3'b000;
    sample_ack = 1'b0;
  endtask

  task automatic apply_reset();
    n_rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // Reset holds everything at zero even with requests pending.
  task automatic test_reset();
    n_rst = 1'b0;
    idle_inputs();
    acc_ready = 1'b1;
    src_en    = 3'b111;
    @(negedge clk);
    @(negedge clk);
    checks++; if (sample_valid !== 1'b0) begin $display("FAIL reset_valid got=%0b exp=0", sample_valid); failures++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy got=%0b exp=0", busy); failures++; end
    checks++; if (rd !== 3'b000) begin $display("FAIL reset_read got=%b exp=000", rd); failures++; end
    checks++; if (sample_data !== 48'h0) begin $display("FAIL reset_data got=%h exp=0", sample_data); failures++; end
    checks++; if (sample_src !== 2'd0) begin $display("FAIL reset_src got=%0d exp=0", sample_src); failures++; end
    checks++; if (timeout_err !== 1'b0) begin $display("FAIL reset_tmo got=%0b exp=0", timeout_err); failures++; end
    checks++; if (drop_count !== 8'd0) begin $display("FAIL reset_drop got=%0d exp=0", drop_count); failures++; end
    n_rst = 1'b1;
    idle_inputs();
  endtask

  // All sources ready, ack held: acc, gyro, mag, acc, one sample per 2 cycles.
  task automatic test_round_robin();
    logic [1:0]  exp_src;
    logic [47:0] exp_data;
    apply_reset();
    src_en     = 3'b111;
    acc_ready  = 1'b1;
    gyro_ready = 1'b1;
    mag_ready  = 1'b1;
    sample_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_src  = (i == 3) ? 2'd0 : 2'(i);
      exp_data = (exp_src == 2'd0) ? ACC_D : (exp_src == 2'd1) ? GYRO_D : MAG_D;
      step();
      checks++; if (sample_valid !== 1'b1) begin $display("FAIL rr_valid[%0d] got=%0b exp=1", i, sample_valid); failures++; end
      checks++; if (sample_src !== exp_src) begin $display("FAIL rr_src[%0d] got=%0d exp=%0d", i, sample_src, exp_src); failures++; end
      checks++; if (sample_data !== exp_data) begin $display("FAIL rr_data[%0d] got=%h exp=%h", i, sample_data, exp_data); failures++; end
      checks++; if (rd !== (3'b001 << exp_src)) begin $display("FAIL rr_read[%0d] got=%b exp=%b", i, rd, 3'b001 << exp_src); failures++; end
      step();
      checks++; if (sample_valid !== 1'b0 || rd !== 3'b000 || busy !== 1'b0) begin
        $display("FAIL rr_gap[%0d] got valid=%0b read=%b busy=%0b exp 0/000/0", i, sample_valid, rd, busy); failures++; end
    end
  endtask

  // Gyro sample held for 4 cycles while ack is low for 3, then accepted.
  task automatic test_hold();
    int vcount;
    apply_reset();
    src_en     = 3'b111;
    gyro_data  = 48'h0001_0002_0003;
    gyro_ready = 1'b1;
    vcount     = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (!sample_valid) break;
      vcount++;
      checks++; if (sample_src !== 2'd1 || sample_data !== 48'h0001_0002_0003) begin
        $display("FAIL hold_data[%0d] got src=%0d data=%h exp src=1 data=000100020003", vcount, sample_src, sample_data); failures++; end
      checks++; if (rd !== ((vcount == 1) ? 3'b010 : 3'b000)) begin
        $display("FAIL hold_read[%0d] got=%b exp=%b", vcount, rd, (vcount == 1) ? 3'b010 : 3'b000); failures++; end
      if (vcount == 1) gyro_ready = 1'b0;
      if (vcount == 4) sample_ack = 1'b1;
    end
    sample_ack = 1'b0;
    checks++; if (vcount !== 4) begin $display("FAIL hold_len got=%0d exp=4", vcount); failures++; end
    checks++; if (timeout_err !== 1'b0 || drop_count !== 8'd0) begin
      $display("FAIL hold_nodrop got tmo=%0b drops=%0d exp 0/0", timeout_err, drop_count); failures++; end
  endtask

  // Mag request never acked: 4-cycle presentations, 300 drops saturate at 255.
  task automatic test_timeout();
    int drops, run, bad_runs, reads, bad_reads;
    apply_reset();
    src_en    = 3'b100;
    mag_ready = 1'b1;
    drops = 0; run = 0; bad_runs = 0; reads = 0; bad_reads = 0;
    for (int c = 0; c < 2000 && drops < 300; c++) begin
      step();
      if (rd == 3'b100) reads++;
      else if (rd != 3'b000) bad_reads++;
      if (rd != 3'b000 && !(sample_valid && run == 0)) bad_reads++;
      if (sample_valid) begin
        run++;
        if (sample_src != 2'd2) bad_runs++;
      end else begin
        if (run != 0 && run != 4) bad_runs++;
        if (run != 0 && !timeout_err) bad_runs++;
        run = 0;
      end
      if (timeout_err) begin
        drops++;
        if (drops == 1) begin
          checks++; if (drop_count !== 8'd1) begin $display("FAIL tmo_first_drop got=%0d exp=1", drop_count); failures++; end
        end
      end
    end
    checks++; if (drops !== 300) begin $display("FAIL tmo_pulses got=%0d exp=300", drops); failures++; end
    checks++; if (reads !== 300) begin $display("FAIL tmo_reads got=%0d exp=300", reads); failures++; end
    checks++; if (bad_reads !== 0) begin $display("FAIL tmo_bad_reads got=%0d exp=0", bad_reads); failures++; end
    checks++; if (bad_runs !== 0) begin $display("FAIL tmo_run_shape got=%0d exp=0", bad_runs); failures++; end
    checks++; if (drop_count !== 8'd255) begin $display("FAIL tmo_saturate got=%0d exp=255", drop_count); failures++; end
  endtask

  // One drop, then ack in the 4th PRESENT cycle of the next sample: accepted.
  task automatic test_ack_at_limit();
    bit seen;
    apply_reset();
    src_en    = 3'b100;
    mag_ready = 1'b1;
    seen      = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (timeout_err) seen = 1'b1;
    end
    checks++; if (!seen || drop_count !== 8'd1) begin
      $display("FAIL lim_first_drop got seen=%0b drops=%0d exp 1/1", seen, drop_count); failures++; end
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++; if (sample_valid !== 1'b1 || busy !== 1'b1) begin
        $display("FAIL lim_valid[%0d] got valid=%0b busy=%0b exp 1/1", c, sample_valid, busy); failures++; end
      if (c == 1) begin
        checks++; if (rd !== 3'b100) begin $display("FAIL lim_read got=%b exp=100", rd); failures++; end
      end
      if (c == 4) begin
        sample_ack = 1'b1;
        mag_ready  = 1'b0;
      end
    end
    step();
    checks++; if (sample_valid !== 1'b0 || timeout_err !== 1'b0 || drop_count !== 8'd1) begin
      $display("FAIL lim_accept got valid=%0b tmo=%0b drops=%0d exp 0/0/1", sample_valid, timeout_err, drop_count); failures++; end
    sample_ack = 1'b0;
    step();
    checks++; if (timeout_err !== 1'b0 || drop_count !== 8'd1) begin
      $display("FAIL lim_after got tmo=%0b drops=%0d exp 0/1", timeout_err, drop_count); failures++; end
  endtask

  // Gyro masked: acc and mag alternate, gyro never read.
  task automatic test_masked();
    logic [1:0] exp_src;
    int gyro_seen;
    apply_reset();
    src_en     = 3'b101;
    acc_ready  = 1'b1;
    gyro_ready = 1'b1;
    mag_ready  = 1'b1;
    sample_ack = 1'b1;
    gyro_seen  = 0;
    for (int i = 0; i < 6; i++) begin
      exp_src = (i % 2 == 0) ? 2'd0 : 2'd2;
      step();
      if (gyro_read) gyro_seen++;
      checks++; if (sample_valid !== 1'b1 || sample_src !== exp_src || rd !== (3'b001 << exp_src)) begin
        $display("FAIL mask_grant[%0d] got valid=%0b src=%0d read=%b exp 1/%0d/%b", i, sample_valid, sample_src, rd, exp_src, 3'b001 << exp_src); failures++; end
      step();
      if (gyro_read) gyro_seen++;
    end
    checks++; if (gyro_seen !== 0) begin $display("FAIL mask_gyro got=%0d exp=0", gyro_seen); failures++; end
  endtask

  // Reset mid-PRESENT clears everything at once; acc wins the next grant.
  task automatic test_reset_mid();
    apply_reset();
    src_en     = 3'b111;
    gyro_ready = 1'b1;
    step();
    checks++; if (sample_valid !== 1'b1 || sample_src !== 2'd1) begin
      $display("FAIL mid_pre got valid=%0b src=%0d exp 1/1", sample_valid, sample_src); failures++; end
    step();
    #2;
    n_rst = 1'b0;
    #1;
    checks++; if (sample_valid !== 1'b0 || busy !== 1'b0 || rd !== 3'b000) begin
      $display("FAIL mid_async got valid=%0b busy=%0b read=%b exp 0/0/000", sample_valid, busy, rd); failures++; end
    checks++; if (sample_data !== 48'h0 || sample_src !== 2'd0 || timeout_err !== 1'b0 || drop_count !== 8'd0) begin
      $display("FAIL mid_regs got data=%h src=%0d tmo=%0b drops=%0d exp 0/0/0/0", sample_data, sample_src, timeout_err, drop_count); failures++; end
    acc_ready = 1'b1;
    @(negedge clk);
    n_rst = 1'b1;
    step();
    checks++; if (sample_valid !== 1'b1 || sample_src !== 2'd0 || rd !== 3'b001 || sample_data !== ACC_D) begin
      $display("FAIL mid_regrant got valid=%0b src=%0d read=%b data=%h exp 1/0/001/%h", sample_valid, sample_src, rd, sample_data, ACC_D); failures++; end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_hold();
    test_timeout();
    test_ack_at_limit();
    test_masked();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
